weight_s_sum_mmap_s_axi_rd_responder: RTL and testbench

//  AXI4 read-channel slave (AR/R) backed by a word-addressed memory array. It is the

---
 rtl/weight_s_sum_mmap_s_axi_rd_responder_pkg.sv | 33 +++
 rtl/weight_s_sum_mmap_s_axi_rd_fifo.sv | 61 ++++++
 rtl/weight_s_sum_mmap_s_axi_rd_responder.sv | 182 ++++++++++++++++++
 tb/tb_weight_s_sum_mmap_s_axi_rd_responder.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_s_sum_mmap_s_axi_rd_responder_pkg.sv
// Shared types for the weight_s_sum m_axi read responder.
// RRESP/burst encodings, AR queue entry struct, FSM states.
package weight_s_sum_mmap_s_axi_rd_responder_pkg;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    // Fields are sized for the widest supported configuration;
    // the top zero-extends narrower address/ID buses into them.
    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
        burst_e      burst;
        logic [15:0] id;
    } ar_entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } rd_state_e;

    function automatic logic burst_ok(input burst_e b);
        return (b == BURST_FIXED) || (b == BURST_INCR);
    endfunction

endpackage

// File: rtl/weight_s_sum_mmap_s_axi_rd_fifo.sv
// Generic synchronous FIFO, registered storage, head shown on o_dout.
// Ports: clk, reset_n, i_push/i_din, i_pop, o_dout, o_full, o_empty.
module weight_s_sum_mmap_s_axi_rd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= nxt(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= nxt(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/weight_s_sum_mmap_s_axi_rd_responder.sv
// AXI4 read slave (AR/R) over a word-addressed memory with backdoor preload.
// Ports: clk/reset_n, s_axi_ar*, s_axi_r*, mem_we/addr/din, num_outstanding.
module weight_s_sum_mmap_s_axi_rd_responder
    import weight_s_sum_mmap_s_axi_rd_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int MEM_DEPTH  = 1024,
    parameter int AR_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic [7:0]                   s_axi_arlen,
    input  logic [1:0]                   s_axi_arburst,
    input  logic [ID_WIDTH-1:0]          s_axi_arid,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    output logic [ID_WIDTH-1:0]          s_axi_rid,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]        mem_din,
    output logic [$clog2(AR_DEPTH+1)-1:0] num_outstanding
);

    localparam int MAW = $clog2(MEM_DEPTH);
    localparam int OFF = $clog2(DATA_WIDTH / 8);
    localparam int OCW = $clog2(AR_DEPTH + 1);
    localparam int ARW = $bits(ar_entry_t);
    localparam int RW  = DATA_WIDTH + 3 + ID_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    rd_state_e         r_state;
    logic [63:0]       r_idx;
    logic [7:0]        r_cnt;
    logic              r_fixed;
    logic              r_burst_err;
    logic [ID_WIDTH-1:0] r_id;
    logic              r_ar_en;
    logic [OCW-1:0]    r_outstanding;

    ar_entry_t         w_ar_in;
    ar_entry_t         w_ar_head;
    logic              w_ar_full;
    logic              w_ar_empty;
    logic              w_ar_hs;
    logic              w_ar_pop;
    logic              w_unused_id;

    logic              w_issue;
    logic              w_err;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [1:0]        w_resp;
    logic [RW-1:0]     w_r_din;
    logic [RW-1:0]     w_r_dout;
    logic              w_r_full;
    logic              w_r_empty;
    logic              w_r_pop;
    logic              w_r_last_hs;

    // Backdoor port; memory is deliberately never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            r_mem[mem_addr] <= mem_din;
        end
    end

    assign w_ar_in = '{
        addr:  64'(s_axi_araddr),
        len:   s_axi_arlen,
        burst: burst_e'(s_axi_arburst),
        id:    16'(s_axi_arid)
    };

    // Outstanding limit also bounds the queue, since an entry popped
    // into the FSM still counts until its RLAST beat is accepted.
    assign s_axi_arready = r_ar_en & ~w_ar_full
                         & (r_outstanding != OCW'(AR_DEPTH));
    assign w_ar_hs  = s_axi_arvalid & s_axi_arready;
    assign w_ar_pop = (r_state == ST_IDLE) & ~w_ar_empty;

    assign w_unused_id = |(w_ar_head.id >> ID_WIDTH);

    weight_s_sum_mmap_s_axi_rd_fifo #(
        .WIDTH (ARW),
        .DEPTH (AR_DEPTH)
    ) u_ar_q (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_ar_hs),
        .i_din   (w_ar_in),
        .i_pop   (w_ar_pop),
        .o_dout  (w_ar_head),
        .o_full  (w_ar_full),
        .o_empty (w_ar_empty)
    );

    // The output buffer entry doubles as the memory read register:
    // data is captured at the issue edge, which makes reads read-first.
    assign w_issue   = (r_state == ST_BURST) & ~w_r_full;
    assign w_err     = r_burst_err | (r_idx >= 64'(MEM_DEPTH));
    assign w_rd_word = w_err ? '0 : r_mem[r_idx[MAW-1:0]];
    assign w_resp    = w_err ? RRESP_SLVERR : RRESP_OKAY;
    assign w_r_din   = {w_rd_word, w_resp, (r_cnt == 8'd0), r_id};
    assign w_r_pop   = ~w_r_empty & s_axi_rready;

    weight_s_sum_mmap_s_axi_rd_fifo #(
        .WIDTH (RW),
        .DEPTH (2)
    ) u_r_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_issue),
        .i_din   (w_r_din),
        .i_pop   (w_r_pop),
        .o_dout  (w_r_dout),
        .o_full  (w_r_full),
        .o_empty (w_r_empty)
    );

    assign s_axi_rvalid = ~w_r_empty;
    assign s_axi_rid    = w_r_dout[ID_WIDTH-1:0];
    assign s_axi_rlast  = w_r_dout[ID_WIDTH];
    assign s_axi_rresp  = w_r_dout[ID_WIDTH+2:ID_WIDTH+1];
    assign s_axi_rdata  = w_r_dout[RW-1:ID_WIDTH+3];

    assign w_r_last_hs     = w_r_pop & s_axi_rlast;
    assign num_outstanding = r_outstanding;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_fixed       <= 1'b0;
            r_burst_err   <= 1'b0;
            r_id          <= '0;
            r_ar_en       <= 1'b0;
            r_outstanding <= '0;
        end else begin
            r_ar_en <= 1'b1;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_ar_pop) begin
                        r_idx       <= w_ar_head.addr >> OFF;
                        r_cnt       <= w_ar_head.len;
                        r_fixed     <= (w_ar_head.burst == BURST_FIXED);
                        r_burst_err <= ~burst_ok(w_ar_head.burst);
                        r_id        <= w_ar_head.id[ID_WIDTH-1:0];
                        r_state     <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_issue) begin
                        if (r_cnt == 8'd0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                        if (!r_fixed) begin
                            r_idx <= r_idx + 64'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            case ({w_ar_hs, w_r_last_hs})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_s_sum_mmap_s_axi_rd_responder.sv
// Directed self-checking bench for the AXI read responder.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_weight_s_sum_mmap_s_axi_rd_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [1:0]  s_axi_arburst;
    logic [0:0]  s_axi_arid;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic [0:0]  s_axi_rid;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic [2:0]  num_outstanding;

    int errors = 0;
    int checks = 0;

    logic [31:0] cap_data [16];
    logic [1:0]  cap_resp [16];
    logic        cap_last [16];
    logic [0:0]  cap_id   [16];
    int          cap_n;

    weight_s_sum_mmap_s_axi_rd_responder dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .s_axi_arvalid   (s_axi_arvalid),
        .s_axi_arready   (s_axi_arready),
        .s_axi_araddr    (s_axi_araddr),
        .s_axi_arlen     (s_axi_arlen),
        .s_axi_arburst   (s_axi_arburst),
        .s_axi_arid      (s_axi_arid),
        .s_axi_rvalid    (s_axi_rvalid),
        .s_axi_rready    (s_axi_rready),
        .s_axi_rdata     (s_axi_rdata),
        .s_axi_rresp     (s_axi_rresp),
        .s_axi_rlast     (s_axi_rlast),
        .s_axi_rid       (s_axi_rid),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_din         (mem_din),
        .num_outstanding (num_outstanding)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic ar_send(input logic [31:0] a, input logic [7:0] l,
                           input logic [1:0] b, input logic id);
        bit done;
        done = 1'b0;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = a;
        s_axi_arlen   = l;
        s_axi_arburst = b;
        s_axi_arid    = id;
        for (int c = 0; c < 20 && !done; c++) begin
            if (s_axi_arready) done = 1'b1;
            @(negedge clk);
        end
        s_axi_arvalid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL ar_handshake addr=%0h: got no arready, required arready=1", a);
        end
    endtask

    task automatic collect(input int n);
        cap_n = 0;
        s_axi_rready = 1'b1;
        for (int c = 0; c < 40 && cap_n < n; c++) begin
            if (s_axi_rvalid) begin
                cap_data[cap_n] = s_axi_rdata;
                cap_resp[cap_n] = s_axi_rresp;
                cap_last[cap_n] = s_axi_rlast;
                cap_id[cap_n]   = s_axi_rid;
                cap_n++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        s_axi_arvalid = 1'b0;
        s_axi_araddr = '0;
        s_axi_arlen = '0;
        s_axi_arburst = 2'b01;
        s_axi_arid = '0;
        s_axi_rready = 1'b0;
        mem_we = 1'b0;
        mem_addr = '0;
        mem_din = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_axi_arready, s_axi_rvalid, s_axi_rlast} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl arready/rvalid/rlast got %b required 000",
                     {s_axi_arready, s_axi_rvalid, s_axi_rlast});
        end
        checks++;
        if ({s_axi_rdata, s_axi_rresp, s_axi_rid} !== 35'd0) begin
            errors++;
            $display("FAIL reset_data rdata=%0h rresp=%0d rid=%0d required all 0",
                     s_axi_rdata, s_axi_rresp, s_axi_rid);
        end
        checks++;
        if (num_outstanding !== 3'd0) begin
            errors++;
            $display("FAIL reset_outstanding got %0d required 0", num_outstanding);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_arready got %b required 1", s_axi_arready);
        end
        for (int i = 0; i < 1024; i++) begin
            mem_we = 1'b1;
            mem_addr = 10'(i);
            mem_din = 32'(i);
            @(negedge clk);
        end
        mem_we = 1'b0;
    endtask

    task automatic test_single_incr();
        logic exp_v;
        s_axi_rready = 1'b1;
        ar_send(32'h0, 8'd3, 2'b01, 1'b1);
        for (int k = 0; k < 7; k++) begin
            exp_v = (k >= 2 && k <= 5);
            checks++;
            if (s_axi_rvalid !== exp_v) begin
                errors++;
                $display("FAIL t1_rvalid cyc%0d got %b required %b", k, s_axi_rvalid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (s_axi_rdata !== 32'(k - 2) || s_axi_rlast !== (k == 5)
                    || s_axi_rid !== 1'b1 || s_axi_rresp !== 2'b00) begin
                    errors++;
                    $display("FAIL t1_beat%0d got data=%0h last=%b id=%0d resp=%0d required data=%0h last=%b id=1 resp=0",
                             k - 2, s_axi_rdata, s_axi_rlast, s_axi_rid, s_axi_rresp,
                             k - 2, (k == 5));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic rr;
        logic pv, pr, pl;
        logic [31:0] pd;
        int n;
        rr = 1'b0;
        pv = 1'b0;
        pr = 1'b0;
        pl = 1'b0;
        pd = '0;
        n = 0;
        s_axi_rready = 1'b0;
        ar_send(32'h10, 8'd7, 2'b01, 1'b0);
        for (int c = 0; c < 60 && n < 8; c++) begin
            s_axi_rready = rr;
            rr = ~rr;
            if (pv && !pr) begin
                checks++;
                if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== pd || s_axi_rlast !== pl) begin
                    errors++;
                    $display("FAIL t2_stable got v=%b d=%0h l=%b required v=1 d=%0h l=%b",
                             s_axi_rvalid, s_axi_rdata, s_axi_rlast, pd, pl);
                end
            end
            if (s_axi_rvalid && s_axi_rready) begin
                checks++;
                if (s_axi_rdata !== 32'(4 + n) || s_axi_rlast !== (n == 7)
                    || s_axi_rresp !== 2'b00) begin
                    errors++;
                    $display("FAIL t2_beat%0d got d=%0h l=%b r=%0d required d=%0h l=%b r=0",
                             n, s_axi_rdata, s_axi_rlast, s_axi_rresp, 4 + n, (n == 7));
                end
                n++;
            end
            pv = s_axi_rvalid;
            pr = s_axi_rready;
            pd = s_axi_rdata;
            pl = s_axi_rlast;
            @(negedge clk);
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL t2_count got %0d beats required 8", n);
        end
        checks++;
        if (s_axi_rvalid !== 1'b0 || num_outstanding !== 3'd0) begin
            errors++;
            $display("FAIL t2_drain got rvalid=%b outst=%0d required 0 0",
                     s_axi_rvalid, num_outstanding);
        end
    endtask

    task automatic test_back_to_back();
        int b, p;
        logic ev;
        logic [31:0] ed;
        s_axi_rready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ar_send(32'(64 * (i + 1)), 8'd3, 2'b01, 1'(i % 2));
        end
        repeat (3) @(negedge clk);
        checks++;
        if (s_axi_arready !== 1'b0 || num_outstanding !== 3'd4) begin
            errors++;
            $display("FAIL t3_full got arready=%b outst=%0d required 0 4",
                     s_axi_arready, num_outstanding);
        end
        s_axi_rready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b = i / 5;
            p = i % 5;
            ev = (p != 4);
            ed = 32'(16 * (b + 1) + p);
            checks++;
            if (s_axi_rvalid !== ev || (ev && (s_axi_rdata !== ed
                || s_axi_rlast !== (p == 3) || s_axi_rid !== 1'(b % 2)))) begin
                errors++;
                $display("FAIL t3_slot%0d got v=%b d=%0h l=%b id=%0d required v=%b d=%0h l=%b id=%0d",
                         i, s_axi_rvalid, s_axi_rdata, s_axi_rlast, s_axi_rid,
                         ev, ed, (p == 3), b % 2);
            end
            @(negedge clk);
        end
        checks++;
        if (num_outstanding !== 3'd0 || s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL t3_drain got outst=%0d arready=%b required 0 1",
                     num_outstanding, s_axi_arready);
        end
    endtask

    task automatic test_errors();
        s_axi_rready = 1'b1;
        ar_send(32'hFF8, 8'd3, 2'b01, 1'b0);
        collect(4);
        checks++;
        if (cap_n != 4) begin
            errors++;
            $display("FAIL t4_oob_count got %0d required 4", cap_n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (cap_data[i] !== ((i < 2) ? 32'(1022 + i) : 32'd0)
                    || cap_resp[i] !== ((i < 2) ? 2'b00 : 2'b10)
                    || cap_last[i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL t4_oob_beat%0d got d=%0h r=%0d l=%b", i,
                             cap_data[i], cap_resp[i], cap_last[i]);
                end
            end
        end
        ar_send(32'h0, 8'd1, 2'b10, 1'b1);
        collect(2);
        checks++;
        if (cap_n != 2 || cap_data[0] !== 32'd0 || cap_data[1] !== 32'd0
            || cap_resp[0] !== 2'b10 || cap_resp[1] !== 2'b10
            || cap_last[0] !== 1'b0 || cap_last[1] !== 1'b1 || cap_id[1] !== 1'b1) begin
            errors++;
            $display("FAIL t4_wrap got n=%0d r=%0d,%0d l=%b,%b required n=2 r=2,2 l=0,1",
                     cap_n, cap_resp[0], cap_resp[1], cap_last[0], cap_last[1]);
        end
        ar_send(32'h4, 8'd0, 2'b11, 1'b0);
        collect(1);
        checks++;
        if (cap_n != 1 || cap_data[0] !== 32'd0 || cap_resp[0] !== 2'b10
            || cap_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL t4_rsvd got n=%0d d=%0h r=%0d l=%b required n=1 d=0 r=2 l=1",
                     cap_n, cap_data[0], cap_resp[0], cap_last[0]);
        end
    endtask

    task automatic test_fixed_read_first();
        s_axi_rready = 1'b1;
        ar_send(32'h8, 8'd2, 2'b00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'd2 || s_axi_rlast !== 1'b0) begin
            errors++;
            $display("FAIL t5_beat0 got v=%b d=%0h l=%b required v=1 d=2 l=0",
                     s_axi_rvalid, s_axi_rdata, s_axi_rlast);
        end
        mem_we = 1'b1;
        mem_addr = 10'd2;
        mem_din = 32'hAA;
        @(negedge clk);
        mem_we = 1'b0;
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'd2 || s_axi_rlast !== 1'b0) begin
            errors++;
            $display("FAIL t5_beat1_old got v=%b d=%0h l=%b required v=1 d=2 l=0",
                     s_axi_rvalid, s_axi_rdata, s_axi_rlast);
        end
        @(negedge clk);
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'hAA || s_axi_rlast !== 1'b1
            || s_axi_rresp !== 2'b00) begin
            errors++;
            $display("FAIL t5_beat2_new got v=%b d=%0h l=%b r=%0d required v=1 d=aa l=1 r=0",
                     s_axi_rvalid, s_axi_rdata, s_axi_rlast, s_axi_rresp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        int n;
        int seen;
        bit hit;
        n = 0;
        seen = 0;
        hit = 1'b0;
        s_axi_rready = 1'b1;
        ar_send(32'h0, 8'd7, 2'b01, 1'b1);
        for (int c = 0; c < 20 && !hit; c++) begin
            if (s_axi_rvalid) begin
                if (n == 2) hit = 1'b1;
                else n++;
            end
            if (!hit) @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL t6_reach_beat2 got %0d beats required 3", n);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b0 || num_outstanding !== 3'd0) begin
            errors++;
            $display("FAIL t6_async got v=%b ar=%b outst=%0d required 0 0 0",
                     s_axi_rvalid, s_axi_arready, num_outstanding);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (s_axi_rvalid) seen++;
        end
        checks++;
        if (seen != 0 || num_outstanding !== 3'd0 || s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL t6_residual got beats=%0d outst=%0d ar=%b required 0 0 1",
                     seen, num_outstanding, s_axi_arready);
        end
        ar_send(32'h20, 8'd1, 2'b01, 1'b0);
        collect(2);
        checks++;
        if (cap_n != 2 || cap_data[0] !== 32'd8 || cap_data[1] !== 32'd9
            || cap_last[0] !== 1'b0 || cap_last[1] !== 1'b1 || cap_resp[1] !== 2'b00) begin
            errors++;
            $display("FAIL t6_new_ar got n=%0d d=%0h,%0h l=%b,%b required n=2 d=8,9 l=0,1",
                     cap_n, cap_data[0], cap_data[1], cap_last[0], cap_last[1]);
        end
    endtask

    initial begin
        test_reset();
        test_single_incr();
        test_backpressure();
        test_back_to_back();
        test_errors();
        test_fixed_read_first();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
